axis_trigger_gate: RTL and testbench

Multi-channel AXI4-Stream trigger gate between the waveform-playback DMA streams and the RF data converter / loopback capture paths. On a software or external trigger it opens a per-channel transfer window for a programmed number of clock cycles. Optionally it repeats the window a programmed number of times with a programmed gap. It is the parametrised successor of the single-channel GPIO-controlled gate: proper valid/ready handshaking, channel masking, repeat mode, and a parallel configuration bus in place of the bit-banged shift register.

---
 rtl/axis_trigger_gate_pkg.sv | 25 ++
 rtl/trigger_sync_edge.sv | 41 ++++
 rtl/axis_trigger_gate.sv | 235 +++++++++++++++++++++++
 tb/tb_axis_trigger_gate.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/axis_trigger_gate_pkg.sv
// Shared types and constants for the multi-channel AXI4-Stream trigger gate.
package axis_trigger_gate_pkg;

    // Gate controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OPEN = 2'd1,
        GAP  = 2'd2,
        HOLD = 2'd3
    } state_t;

    // Window modes; encoding 3 is reserved and behaves as single
    localparam logic [1:0] MODE_SINGLE = 2'd0;
    localparam logic [1:0] MODE_CONT   = 2'd1;
    localparam logic [1:0] MODE_REPEAT = 2'd2;

    // Depth of the external-trigger synchroniser
    localparam int SYNC_STAGES = 2;

    // Fold the reserved mode encoding onto single mode at latch time
    function automatic logic [1:0] norm_mode(input logic [1:0] mode);
        return (mode == 2'd3) ? MODE_SINGLE : mode;
    endfunction

endpackage

// File: rtl/trigger_sync_edge.sv
// Synchronises an asynchronous trigger, ORs it with a synchronous trigger
// level, and flags the rising edge of the combined level.
// STAGES must be at least 2.
module trigger_sync_edge
    import axis_trigger_gate_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    input  logic sync_in,
    output logic trig_level,
    output logic trig_rise
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              trig_prev_q;
    logic              trig_prev_d;

    // Shift chain, combined level and edge against the previous level
    always_comb begin
        sync_d      = {sync_q[STAGES-2:0], async_in};
        trig_level  = sync_in | sync_q[STAGES-1];
        trig_rise   = trig_level & ~trig_prev_q;
        trig_prev_d = trig_level;
    end

    // Synchroniser flops and registered copy of the trigger level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q      <= '0;
            trig_prev_q <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            trig_prev_q <= trig_prev_d;
        end
    end

endmodule

// File: rtl/axis_trigger_gate.sv
// Multi-channel AXI4-Stream trigger gate. A trigger edge opens a transfer
// window on all enabled channels for a latched number of cycles, optionally
// repeated with a gap, or held open while the trigger stays high.
// Optional feature macro: AXIS_TRIGGER_GATE_TRIG_COUNT_EN adds trig_count.
module axis_trigger_gate
    import axis_trigger_gate_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 256,
    parameter int CNT_W  = 32,
    parameter int REP_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH*DATA_W-1:0] s_axis_tdata,
    input  logic [NUM_CH-1:0]        s_axis_tvalid,
    output logic [NUM_CH-1:0]        s_axis_tready,
    output logic [NUM_CH*DATA_W-1:0] m_axis_tdata,
    output logic [NUM_CH-1:0]        m_axis_tvalid,
    input  logic [NUM_CH-1:0]        m_axis_tready,
    input  logic                     sw_trigger,
    input  logic                     ext_trigger,
    input  logic [1:0]               cfg_mode,
    input  logic [CNT_W-1:0]         cfg_len,
    input  logic [CNT_W-1:0]         cfg_gap,
    input  logic [REP_W-1:0]         cfg_reps,
    input  logic [NUM_CH-1:0]        ch_enable,
    input  logic                     flush,
    output logic                     gate_open,
    output logic                     busy,
    output logic                     done
`ifdef AXIS_TRIGGER_GATE_TRIG_COUNT_EN
    ,
    output logic [31:0]              trig_count
`endif
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);

    logic trig_level;
    logic trig_rise;

    state_t           state_q,   state_d;
    logic [1:0]       mode_q,    mode_d;
    logic [CNT_W-1:0] len_q,     len_d;
    logic [CNT_W-1:0] gap_q,     gap_d;
    logic [REP_W-1:0] reps_q,    reps_d;
    logic [CNT_W-1:0] len_cnt_q, len_cnt_d;
    logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             done_q,    done_d;

    logic window_end;
    logic more_reps;
    logic gap_end;

    trigger_sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_trig (
        .clk        (clk),
        .reset      (reset),
        .async_in   (ext_trigger),
        .sync_in    (sw_trigger),
        .trig_level (trig_level),
        .trig_rise  (trig_rise)
    );

    // Shared decisions used by both the state and counter logic
    always_comb begin
        window_end = (len_cnt_q == len_q);
        more_reps  = (mode_q == MODE_REPEAT) && (rep_cnt_q < reps_q);
        gap_end    = (gap_cnt_q == gap_q);
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; trigger edges outside IDLE are ignored
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (trig_rise) begin
                    state_d = OPEN;
                end
            end
            OPEN: begin
                if (mode_q == MODE_CONT) begin
                    if (!trig_level) begin
                        state_d = HOLD;
                    end
                end else if (window_end) begin
                    if (more_reps) begin
                        state_d = (gap_q == '0) ? OPEN : GAP;
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            GAP: begin
                if (gap_end) begin
                    state_d = OPEN;
                end
            end
            HOLD: begin
                if (!trig_level) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state; done is registered so it lands in IDLE
    always_comb begin
        gate_open = (state_q == OPEN);
        busy      = (state_q != IDLE);
        done_d    = (state_q == HOLD) && !trig_level;
        done      = done_q;
    end

    // Config shadow latch and saturating window/gap/repeat counters
    always_comb begin
        mode_d    = mode_q;
        len_d     = len_q;
        gap_d     = gap_q;
        reps_d    = reps_q;
        len_cnt_d = len_cnt_q;
        gap_cnt_d = gap_cnt_q;
        rep_cnt_d = rep_cnt_q;
        case (state_q)
            IDLE: begin
                if (trig_rise) begin
                    mode_d    = norm_mode(cfg_mode);
                    len_d     = (cfg_len == '0) ? CNT_ONE : cfg_len;
                    gap_d     = cfg_gap;
                    reps_d    = (cfg_reps == '0) ? REP_ONE : cfg_reps;
                    len_cnt_d = CNT_ONE;
                    gap_cnt_d = '0;
                    rep_cnt_d = REP_ONE;
                end
            end
            OPEN: begin
                if (mode_q != MODE_CONT) begin
                    if (window_end) begin
                        if (more_reps) begin
                            if (gap_q == '0) begin
                                len_cnt_d = CNT_ONE;
                                rep_cnt_d = (rep_cnt_q == '1) ? rep_cnt_q : rep_cnt_q + REP_ONE;
                            end else begin
                                gap_cnt_d = CNT_ONE;
                            end
                        end
                    end else begin
                        len_cnt_d = (len_cnt_q == '1) ? len_cnt_q : len_cnt_q + CNT_ONE;
                    end
                end
            end
            GAP: begin
                if (gap_end) begin
                    len_cnt_d = CNT_ONE;
                    gap_cnt_d = '0;
                    rep_cnt_d = (rep_cnt_q == '1) ? rep_cnt_q : rep_cnt_q + REP_ONE;
                end else begin
                    gap_cnt_d = (gap_cnt_q == '1) ? gap_cnt_q : gap_cnt_q + CNT_ONE;
                end
            end
            default: ;
        endcase
    end

    // Shadow, counter and done flops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q    <= MODE_SINGLE;
            len_q     <= '0;
            gap_q     <= '0;
            reps_q    <= '0;
            len_cnt_q <= '0;
            gap_cnt_q <= '0;
            rep_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            len_q     <= len_d;
            gap_q     <= gap_d;
            reps_q    <= reps_d;
            len_cnt_q <= len_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            rep_cnt_q <= rep_cnt_d;
            done_q    <= done_d;
        end
    end

    // Per-channel combinational gating; flush only zeroes data
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign m_axis_tvalid[gi] = s_axis_tvalid[gi] & gate_open & ch_enable[gi];
            assign s_axis_tready[gi] = m_axis_tready[gi] & gate_open & ch_enable[gi];
            assign m_axis_tdata[gi*DATA_W +: DATA_W] =
                flush ? '0 : s_axis_tdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

`ifdef AXIS_TRIGGER_GATE_TRIG_COUNT_EN
    logic [31:0] trig_count_q, trig_count_d;

    // Count accepted trigger edges; wraps naturally at 2^32
    always_comb begin
        trig_count_d = trig_count_q;
        if ((state_q == IDLE) && trig_rise) begin
            trig_count_d = trig_count_q + 32'd1;
        end
        trig_count = trig_count_q;
    end

    // Trigger count flop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trig_count_q <= '0;
        end else begin
            trig_count_q <= trig_count_d;
        end
    end
`endif

endmodule

// File: tb/tb_axis_trigger_gate.sv
// Directed bench for axis_trigger_gate: a vector table for the per-channel
// gating, plus hand-written window sequences for timing corner cases.
module tb_axis_trigger_gate;
    import axis_trigger_gate_pkg::*;

    localparam int NUM_CH = 2;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 32;
    localparam int REP_W  = 16;
    localparam int TRACE  = 30;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_CH*DATA_W-1:0] s_axis_tdata;
    logic [NUM_CH-1:0]        s_axis_tvalid;
    logic [NUM_CH-1:0]        s_axis_tready;
    logic [NUM_CH*DATA_W-1:0] m_axis_tdata;
    logic [NUM_CH-1:0]        m_axis_tvalid;
    logic [NUM_CH-1:0]        m_axis_tready;
    logic                     sw_trigger;
    logic                     ext_trigger;
    logic [1:0]               cfg_mode;
    logic [CNT_W-1:0]         cfg_len;
    logic [CNT_W-1:0]         cfg_gap;
    logic [REP_W-1:0]         cfg_reps;
    logic [NUM_CH-1:0]        ch_enable;
    logic                     flush;
    logic                     gate_open;
    logic                     busy;
    logic                     done;

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clk = ~clk;

    axis_trigger_gate #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W),
        .REP_W  (REP_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .sw_trigger    (sw_trigger),
        .ext_trigger   (ext_trigger),
        .cfg_mode      (cfg_mode),
        .cfg_len       (cfg_len),
        .cfg_gap       (cfg_gap),
        .cfg_reps      (cfg_reps),
        .ch_enable     (ch_enable),
        .flush         (flush),
        .gate_open     (gate_open),
        .busy          (busy),
        .done          (done)
    );

    typedef struct {
        logic [1:0]  sv;
        logic [1:0]  mr;
        logic [1:0]  en;
        logic        fl;
        logic [31:0] data;
        logic [1:0]  exp_mv;
        logic [1:0]  exp_sr;
        logic [31:0] exp_md;
    } vec_t;

    localparam int NV     = 10;
    localparam int N_OPEN = 8;
    vec_t vt [NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ones(input int lo, input int hi);
        logic [63:0] m;
        m = '0;
        for (int b = lo; b <= hi; b++) m[b] = 1'b1;
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One trigger-to-idle sequence, tracing open/busy/done and beats per channel.
    // Index 0 is the first open cycle for a sw trigger, or the ext rise cycle.
    task automatic run_case(input string name, input logic [1:0] mode,
                            input logic [31:0] len, input logic [31:0] gap,
                            input logic [15:0] reps, input bit use_ext,
                            input int sw_at, input bit toggle, input logic [1:0] chen,
                            input logic [63:0] exp_open, input logic [63:0] exp_busy,
                            input logic [63:0] exp_done, input int exp_b0, input int exp_b1);
        logic [63:0] ov, bv, dv;
        int b0, b1;
        ov = '0; bv = '0; dv = '0; b0 = 0; b1 = 0;
        cfg_mode = mode; cfg_len = len; cfg_gap = gap; cfg_reps = reps;
        ch_enable = chen; s_axis_tvalid = 2'b11; m_axis_tready = 2'b11; flush = 1'b0;
        if (!use_ext) begin
            sw_trigger = 1'b1;
            tick();
            sw_trigger = 1'b0;
            // Scramble config: the latched copy must govern the window
            cfg_len = 32'd2; cfg_mode = MODE_CONT; cfg_gap = 32'd7; cfg_reps = 16'd9;
        end
        for (int i = 0; i < TRACE; i++) begin
            ext_trigger   = use_ext && (i < 20);
            sw_trigger    = (i == sw_at);
            m_axis_tready = toggle ? {1'b1, ~i[0]} : 2'b11;
            #1;
            ov[i] = gate_open; bv[i] = busy; dv[i] = done;
            b0 += int'(m_axis_tvalid[0] & m_axis_tready[0]);
            b1 += int'(m_axis_tvalid[1] & m_axis_tready[1]);
            tick();
        end
        sw_trigger = 1'b0; ext_trigger = 1'b0;
        $display("case %s: open=%h busy=%h done=%h beats=%0d/%0d", name, ov, bv, dv, b0, b1);
        check({name, " open"}, ov, exp_open);
        check({name, " busy"}, bv, exp_busy);
        check({name, " done"}, dv, exp_done);
        check({name, " beats"}, {32'(b0), 32'(b1)}, {32'(exp_b0), 32'(exp_b1)});
    endtask

    initial begin
        vt[0] = '{2'b11, 2'b11, 2'b11, 1'b0, 32'hABCD1234, 2'b11, 2'b11, 32'hABCD1234};
        vt[1] = '{2'b01, 2'b11, 2'b11, 1'b0, 32'h00110022, 2'b01, 2'b11, 32'h00110022};
        vt[2] = '{2'b11, 2'b10, 2'b11, 1'b0, 32'h33334444, 2'b11, 2'b10, 32'h33334444};
        vt[3] = '{2'b11, 2'b11, 2'b01, 1'b0, 32'h5A5AA5A5, 2'b01, 2'b01, 32'h5A5AA5A5};
        vt[4] = '{2'b11, 2'b00, 2'b01, 1'b0, 32'h0F0FF0F0, 2'b01, 2'b00, 32'h0F0FF0F0};
        vt[5] = '{2'b11, 2'b11, 2'b11, 1'b1, 32'hDEADBEEF, 2'b11, 2'b11, 32'h00000000};
        vt[6] = '{2'b10, 2'b01, 2'b10, 1'b0, 32'h5555AAAA, 2'b10, 2'b00, 32'h5555AAAA};
        vt[7] = '{2'b00, 2'b11, 2'b11, 1'b0, 32'h12345678, 2'b00, 2'b11, 32'h12345678};
        vt[8] = '{2'b11, 2'b11, 2'b11, 1'b0, 32'hCAFEF00D, 2'b00, 2'b00, 32'hCAFEF00D};
        vt[9] = '{2'b11, 2'b11, 2'b11, 1'b1, 32'hCAFEF00D, 2'b00, 2'b00, 32'h00000000};

        reset = 1'b1; sw_trigger = 1'b0; ext_trigger = 1'b0;
        cfg_mode = MODE_SINGLE; cfg_len = 32'd8; cfg_gap = '0; cfg_reps = 16'd1;
        ch_enable = 2'b11; flush = 1'b0;
        s_axis_tvalid = 2'b11; m_axis_tready = 2'b11; s_axis_tdata = 32'h11112222;
        #3;
        check("reset outputs", {59'd0, gate_open, busy, done, m_axis_tvalid, s_axis_tready},
              64'd0);
        tick(); tick();
        reset = 1'b0;
        tick();

        // Gating table: first with the window held open, then closed
        cfg_mode = MODE_CONT; sw_trigger = 1'b1;
        tick();
        check("cont open", {63'd0, gate_open}, 64'd1);
        for (int i = 0; i < NV; i++) begin
            if (i == N_OPEN) begin
                sw_trigger = 1'b0;
                repeat (4) tick();
            end
            s_axis_tvalid = vt[i].sv; m_axis_tready = vt[i].mr;
            ch_enable = vt[i].en; flush = vt[i].fl; s_axis_tdata = vt[i].data;
            #1;
            $display("vec %0d: mv=%b sr=%b md=%h", i, m_axis_tvalid, s_axis_tready, m_axis_tdata);
            check($sformatf("vec %0d", i), {28'd0, m_axis_tvalid, s_axis_tready, m_axis_tdata},
                  {28'd0, vt[i].exp_mv, vt[i].exp_sr, vt[i].exp_md});
            tick();
        end
        flush = 1'b0;
        repeat (3) tick();

        // Multi-cycle window sequences
        run_case("single len8", MODE_SINGLE, 8, 0, 1, 1'b0, 3, 1'b0, 2'b11,
                 ones(0, 7), ones(0, 8), ones(9, 9), 8, 8);
        run_case("repeat 4/3x3", MODE_REPEAT, 4, 3, 3, 1'b0, 5, 1'b0, 2'b11,
                 ones(0, 3) | ones(7, 10) | ones(14, 17), ones(0, 18), ones(19, 19), 12, 12);
        run_case("repeat gap0", MODE_REPEAT, 5, 0, 2, 1'b0, -1, 1'b0, 2'b11,
                 ones(0, 9), ones(0, 10), ones(11, 11), 10, 10);
        run_case("cont ext", MODE_CONT, 8, 0, 1, 1'b1, 10, 1'b0, 2'b11,
                 ones(3, 22), ones(3, 23), ones(24, 24), 20, 20);
        run_case("mask toggle", MODE_SINGLE, 8, 0, 1, 1'b0, -1, 1'b1, 2'b01,
                 ones(0, 7), ones(0, 8), ones(9, 9), 4, 0);
        run_case("len0", MODE_SINGLE, 0, 0, 1, 1'b0, -1, 1'b0, 2'b11,
                 ones(0, 0), ones(0, 1), ones(2, 2), 1, 1);
        run_case("mode3", 2'd3, 2, 5, 4, 1'b0, -1, 1'b0, 2'b11,
                 ones(0, 1), ones(0, 2), ones(3, 3), 2, 2);
        run_case("reps0", MODE_REPEAT, 3, 2, 0, 1'b0, -1, 1'b0, 2'b11,
                 ones(0, 2), ones(0, 3), ones(4, 4), 3, 3);

        // Reset in the third open cycle: immediate low outputs, no done
        begin
            int done_seen;
            done_seen = 0;
            cfg_mode = MODE_SINGLE; cfg_len = 32'd8; ch_enable = 2'b11;
            s_axis_tvalid = 2'b11; m_axis_tready = 2'b11;
            sw_trigger = 1'b1;
            tick();
            sw_trigger = 1'b0;
            tick(); tick();
            check("mid open before reset", {63'd0, gate_open}, 64'd1);
            #2;
            reset = 1'b1;
            #1;
            $display("reset mid-window: open=%b busy=%b mv=%b sr=%b",
                     gate_open, busy, m_axis_tvalid, s_axis_tready);
            check("async reset outputs", {58'd0, gate_open, busy, m_axis_tvalid, s_axis_tready},
                  64'd0);
            tick();
            reset = 1'b0;
            for (int i = 0; i < 15; i++) begin
                done_seen += int'(done);
                tick();
            end
            check("no done after reset", 64'(done_seen), 64'd0);
        end
        run_case("restart", MODE_SINGLE, 8, 0, 1, 1'b0, -1, 1'b0, 2'b11,
                 ones(0, 7), ones(0, 8), ones(9, 9), 8, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
